// File: rtl/spi_transceiver_if.sv
// Bus bundle between an SPI transceiver and the logic that drives it.
// The master modport is the transceiver side; the slave modport is the
// controlling logic that issues words and watches the peripheral pins.
interface spi_transceiver_if #(
    parameter int WORD_WIDTH = 8
) ();

    logic                  execute;
    logic [WORD_WIDTH-1:0] out_word;
    logic                  cs_hold;
    logic                  miso;
    logic                  spi_clk;
    logic                  mosi;
    logic                  cs_n;
    logic [WORD_WIDTH-1:0] in_word;
    logic                  busy;
    logic                  finished;

    modport master (
        input  execute,
        input  out_word,
        input  cs_hold,
        input  miso,
        output spi_clk,
        output mosi,
        output cs_n,
        output in_word,
        output busy,
        output finished
    );

    modport slave (
        output execute,
        output out_word,
        output cs_hold,
        output miso,
        input  spi_clk,
        input  mosi,
        input  cs_n,
        input  in_word,
        input  busy,
        input  finished
    );

endinterface

// File: rtl/spi_transceiver.sv
// Single-word SPI master with configurable mode, bit order and clock divider.
//
// state | meaning
// IDLE  | no transfer; spi_clk at CPOL, mosi high, cs_n as left by last word
// SHIFT | spi_clk toggling, 2*WORD_WIDTH edges, data shifted out and in
// TRAIL | spi_clk parked at CPOL for one half-period after the last edge
// DONE  | one cycle: finished pulse, in_word update, cs_n per cs_hold
module spi_transceiver #(
    parameter int WORD_WIDTH = 8,
    parameter int CLK_DIV    = 1,
    parameter int CPOL       = 0,
    parameter int CPHA       = 0,
    parameter int LSB_FIRST  = 0
) (
    input  logic               clk,
    input  logic               reset,
    spi_transceiver_if.master  bus
);

    localparam int                EDGE_W      = $clog2(2 * WORD_WIDTH + 1);
    localparam logic [EDGE_W-1:0] EDGE_LOAD   = EDGE_W'(2 * WORD_WIDTH);
    localparam logic [EDGE_W-1:0] EDGE_LAST   = EDGE_W'(1);
    localparam logic [7:0]        DIV_LOAD    = 8'(CLK_DIV - 1);
    localparam logic              IDLE_LVL    = (CPOL != 0);
    localparam logic              SAMPLE_LEAD = (CPHA == 0);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        TRAIL,
        DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [7:0]              div_q, div_d;
    logic [EDGE_W-1:0]       edge_q, edge_d;
    logic [WORD_WIDTH-1:0]   tx_q, tx_d;
    logic [WORD_WIDTH-1:0]   rx_q, rx_d;
    logic [WORD_WIDTH-1:0]   in_word_q, in_word_d;
    logic                    hold_q, hold_d;
    logic                    sclk_q, sclk_d;
    logic                    mosi_q, mosi_d;
    logic                    csn_q, csn_d;
    logic                    start;
    logic                    edge_is_lead;

    function automatic logic next_bit(input logic [WORD_WIDTH-1:0] w);
        return (LSB_FIRST != 0) ? w[0] : w[WORD_WIDTH-1];
    endfunction

    function automatic logic [WORD_WIDTH-1:0] shift_tx(input logic [WORD_WIDTH-1:0] w);
        return (LSB_FIRST != 0) ? {1'b0, w[WORD_WIDTH-1:1]} : {w[WORD_WIDTH-2:0], 1'b0};
    endfunction

    function automatic logic [WORD_WIDTH-1:0] shift_rx(input logic [WORD_WIDTH-1:0] w,
                                                       input logic b);
        return (LSB_FIRST != 0) ? {b, w[WORD_WIDTH-1:1]} : {w[WORD_WIDTH-2:0], b};
    endfunction

    // State and datapath registers; reset parks the bus idle with cs_n released.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            div_q     <= '0;
            edge_q    <= '0;
            tx_q      <= '0;
            rx_q      <= '0;
            in_word_q <= '0;
            hold_q    <= 1'b0;
            sclk_q    <= IDLE_LVL;
            mosi_q    <= 1'b1;
            csn_q     <= 1'b1;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            edge_q    <= edge_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            in_word_q <= in_word_d;
            hold_q    <= hold_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            csn_q     <= csn_d;
        end
    end

    // Next-state logic: half-period down-counter drives edges, edge down-counter
    // ends the word; edge parity tells leading from trailing.
    always_comb begin
        state_d      = state_q;
        div_d        = div_q;
        edge_d       = edge_q;
        tx_d         = tx_q;
        rx_d         = rx_q;
        in_word_d    = in_word_q;
        hold_d       = hold_q;
        sclk_d       = sclk_q;
        mosi_d       = mosi_q;
        csn_d        = csn_q;
        start        = 1'b0;
        edge_is_lead = 1'b0;

        case (state_q)
            IDLE: begin
                sclk_d = IDLE_LVL;
                mosi_d = 1'b1;
                if (bus.execute) begin
                    start = 1'b1;
                end
            end

            SHIFT: begin
                if (div_q == '0) begin
                    div_d        = DIV_LOAD;
                    sclk_d       = ~sclk_q;
                    edge_d       = edge_q - EDGE_W'(1);
                    // Edges remaining is even before a leading edge.
                    edge_is_lead = ~edge_q[0];
                    if (edge_is_lead == SAMPLE_LEAD) begin
                        rx_d = shift_rx(rx_q, bus.miso);
                    end else if (edge_q != EDGE_LAST) begin
                        // Final trailing edge in mode CPHA=0 has no bit left to launch.
                        mosi_d = next_bit(tx_q);
                        tx_d   = shift_tx(tx_q);
                    end
                    if (edge_q == EDGE_LAST) begin
                        state_d = TRAIL;
                    end
                end else begin
                    div_d = div_q - 8'd1;
                end
            end

            TRAIL: begin
                sclk_d = IDLE_LVL;
                if (div_q == '0) begin
                    state_d   = DONE;
                    mosi_d    = 1'b1;
                    in_word_d = rx_q;
                    csn_d     = ~hold_q;
                end else begin
                    div_d = div_q - 8'd1;
                end
            end

            DONE: begin
                if (bus.execute) begin
                    start = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Acceptance: CPHA=0 puts the first bit out immediately, CPHA=1 waits
        // for the first leading edge.
        if (start) begin
            state_d = SHIFT;
            div_d   = DIV_LOAD;
            edge_d  = EDGE_LOAD;
            rx_d    = '0;
            hold_d  = bus.cs_hold;
            csn_d   = 1'b0;
            sclk_d  = IDLE_LVL;
            if (CPHA == 0) begin
                mosi_d = next_bit(bus.out_word);
                tx_d   = shift_tx(bus.out_word);
            end else begin
                mosi_d = 1'b1;
                tx_d   = bus.out_word;
            end
        end
    end

    // Pin and status outputs.
    assign bus.spi_clk  = sclk_q;
    assign bus.mosi     = mosi_q;
    assign bus.cs_n     = csn_q;
    assign bus.in_word  = in_word_q;
    assign bus.busy     = (state_q == SHIFT) || (state_q == TRAIL);
    assign bus.finished = (state_q == DONE);

endmodule

// File: tb/tb_spi_transceiver.sv
// Directed bench for spi_transceiver: three configurations, all in loopback.
module tb_spi_transceiver;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  exe   = '0;
    logic [2:0]  hold  = '0;
    logic [31:0] ow [3];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    spi_transceiver_if #(.WORD_WIDTH(8))  b0 ();
    spi_transceiver_if #(.WORD_WIDTH(8))  b1 ();
    spi_transceiver_if #(.WORD_WIDTH(16)) b2 ();

    assign b0.execute  = exe[0];
    assign b0.out_word = ow[0][7:0];
    assign b0.cs_hold  = hold[0];
    assign b0.miso     = b0.mosi;
    assign b1.execute  = exe[1];
    assign b1.out_word = ow[1][7:0];
    assign b1.cs_hold  = hold[1];
    assign b1.miso     = b1.mosi;
    assign b2.execute  = exe[2];
    assign b2.out_word = ow[2][15:0];
    assign b2.cs_hold  = hold[2];
    assign b2.miso     = b2.mosi;

    logic [2:0]  sclk_w, mosi_w, csn_w, busy_w, fin_w;
    logic [31:0] inw_w [3];

    assign sclk_w   = {b2.spi_clk, b1.spi_clk, b0.spi_clk};
    assign mosi_w   = {b2.mosi, b1.mosi, b0.mosi};
    assign csn_w    = {b2.cs_n, b1.cs_n, b0.cs_n};
    assign busy_w   = {b2.busy, b1.busy, b0.busy};
    assign fin_w    = {b2.finished, b1.finished, b0.finished};
    assign inw_w[0] = 32'(b0.in_word);
    assign inw_w[1] = 32'(b1.in_word);
    assign inw_w[2] = 32'(b2.in_word);

    spi_transceiver #(.WORD_WIDTH(8)) u0 (
        .clk(clk), .reset(reset), .bus(b0.master));
    spi_transceiver #(.WORD_WIDTH(8), .CPOL(1), .CPHA(1)) u1 (
        .clk(clk), .reset(reset), .bus(b1.master));
    spi_transceiver #(.WORD_WIDTH(16), .CLK_DIV(4), .LSB_FIRST(1)) u2 (
        .clk(clk), .reset(reset), .bus(b2.master));

    int          fin1, fin2, fin_cnt, cap_n, csn_hi;
    logic [31:0] cap;
    logic        first_mosi;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts a word on instance sel and watches it for ncyc cycles. Captures
    // mosi on every spi_clk rising edge, records finished pulse cycles and
    // counts cycles where cs_n is wrongly high. Optional mid-transfer execute
    // injection and back-to-back second word issued in the first DONE cycle.
    task automatic run_xfer(input int sel, input logic [31:0] word, input logic hv,
                            input int ncyc, input int lsb,
                            input int inj_cyc, input logic [31:0] inj_word,
                            input logic b2b, input logic [31:0] b2b_word);
        logic prev;
        fin1 = -1; fin2 = -1; fin_cnt = 0; cap = '0; cap_n = 0; csn_hi = 0;
        first_mosi = 1'bx;
        exe[sel]  = 1'b1;
        ow[sel]   = word;
        hold[sel] = hv;
        prev = sclk_w[sel];
        for (int c = 1; c <= ncyc; c++) begin
            tick();
            exe[sel] = 1'b0;
            if (c == 1) first_mosi = mosi_w[sel];
            if (!prev && sclk_w[sel]) begin
                if (lsb != 0) cap = cap | (32'(mosi_w[sel]) << cap_n);
                else          cap = {cap[30:0], mosi_w[sel]};
                cap_n++;
            end
            prev = sclk_w[sel];
            if (csn_w[sel] && (busy_w[sel] || (fin_w[sel] && fin_cnt == 0 && hv))) csn_hi++;
            if (fin_w[sel]) begin
                fin_cnt++;
                if (fin1 < 0)      fin1 = c;
                else if (fin2 < 0) fin2 = c;
                if (b2b && fin_cnt == 1) begin
                    exe[sel]  = 1'b1;
                    ow[sel]   = b2b_word;
                    hold[sel] = 1'b0;
                end
            end
            if (c == inj_cyc) begin
                exe[sel] = 1'b1;
                ow[sel]  = inj_word;
            end
        end
    endtask

    initial begin
        int cnt;
        for (int i = 0; i < 3; i++) ow[i] = '0;

        // Reset state
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check("rst_csn",   32'(csn_w[0]),  32'd1);
        check("rst_busy",  32'(busy_w[0]), 32'd0);
        check("rst_fin",   32'(fin_w[0]),  32'd0);
        check("rst_sclk0", 32'(sclk_w[0]), 32'd0);
        check("rst_mosi",  32'(mosi_w[0]), 32'd1);
        check("rst_inw",   inw_w[0],       32'd0);
        check("rst_sclk1", 32'(sclk_w[1]), 32'd1);

        // Mode 0, 0xA6 loopback, cs released after
        run_xfer(0, 32'hA6, 1'b0, 25, 0, 0, 32'h0, 1'b0, 32'h0);
        check("a_bits_n", 32'(cap_n),   32'd8);
        check("a_bits",   cap,          32'hA6);
        check("a_fin_cyc", 32'(fin1),   32'd18);
        check("a_fin_cnt", 32'(fin_cnt), 32'd1);
        check("a_inw",    inw_w[0],     32'hA6);
        check("a_csn_low", 32'(csn_hi), 32'd0);
        check("a_csn_after", 32'(csn_w[0]), 32'd1);
        check("a_busy_after", 32'(busy_w[0]), 32'd0);

        // Mode 3, 0xC3 loopback
        check("b_sclk_idle", 32'(sclk_w[1]), 32'd1);
        run_xfer(1, 32'hC3, 1'b0, 25, 0, 0, 32'h0, 1'b0, 32'h0);
        check("b_bits_n",  32'(cap_n), 32'd8);
        check("b_bits",    cap,        32'hC3);
        check("b_fin_cyc", 32'(fin1),  32'd18);
        check("b_inw",     inw_w[1],   32'hC3);
        check("b_sclk_after", 32'(sclk_w[1]), 32'd1);
        check("b_csn_after",  32'(csn_w[1]),  32'd1);

        // Back-to-back: 0xA6 held, 0xC3 released, issued in DONE
        run_xfer(0, 32'hA6, 1'b1, 45, 0, 0, 32'h0, 1'b1, 32'hC3);
        check("c_fin1",    32'(fin1),        32'd18);
        check("c_gap",     32'(fin2 - fin1), 32'd18);
        check("c_fin_cnt", 32'(fin_cnt),     32'd2);
        check("c_csn_low", 32'(csn_hi),      32'd0);
        check("c_bits_n",  32'(cap_n),       32'd16);
        check("c_bits",    cap,              32'hA6C3);
        check("c_inw",     inw_w[0],         32'hC3);
        check("c_csn_after", 32'(csn_w[0]),  32'd1);

        // Execute with 0xFF while busy is ignored
        run_xfer(0, 32'hA6, 1'b0, 25, 0, 5, 32'hFF, 1'b0, 32'h0);
        check("d_fin_cyc", 32'(fin1),    32'd18);
        check("d_fin_cnt", 32'(fin_cnt), 32'd1);
        check("d_bits",    cap,          32'hA6);
        check("d_inw",     inw_w[0],     32'hA6);

        // 16-bit, divide by 4, LSB first, 0x1234
        run_xfer(2, 32'h1234, 1'b0, 145, 1, 0, 32'h0, 1'b0, 32'h0);
        check("f_first_mosi", 32'(first_mosi), 32'd0);
        check("f_fin_cyc", 32'(fin1),  32'd133);
        check("f_bits_n",  32'(cap_n), 32'd16);
        check("f_bits",    cap,        32'h1234);
        check("f_inw",     inw_w[2],   32'h1234);
        check("f_csn_after", 32'(csn_w[2]), 32'd1);

        // Reset at cycle 7 of a transfer
        exe[0] = 1'b1; ow[0] = 32'hA6; hold[0] = 1'b0;
        cnt = 0;
        for (int c = 1; c <= 7; c++) begin
            tick();
            exe[0] = 1'b0;
            if (fin_w[0]) cnt++;
        end
        check("e_busy_pre", 32'(busy_w[0]), 32'd1);
        reset = 1'b1;
        tick();
        check("e_csn",  32'(csn_w[0]),  32'd1);
        check("e_sclk", 32'(sclk_w[0]), 32'd0);
        check("e_busy", 32'(busy_w[0]), 32'd0);
        check("e_mosi", 32'(mosi_w[0]), 32'd1);
        check("e_inw",  inw_w[0],       32'd0);
        if (fin_w[0]) cnt++;
        reset = 1'b0;
        for (int c = 0; c < 25; c++) begin
            tick();
            if (fin_w[0]) cnt++;
        end
        check("e_no_fin", 32'(cnt), 32'd0);
        check("e_inw_after", inw_w[0], 32'd0);

        // Reset beats a simultaneous execute
        reset = 1'b1; exe[0] = 1'b1; ow[0] = 32'h5A;
        tick();
        check("g_busy", 32'(busy_w[0]), 32'd0);
        check("g_csn",  32'(csn_w[0]),  32'd1);
        reset = 1'b0; exe[0] = 1'b0;
        tick();
        check("g_busy_after", 32'(busy_w[0]), 32'd0);
        check("g_csn_after",  32'(csn_w[0]),  32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_transceiver.md
SPI_TRANSCEIVER -- requirements
Module: spi_transceiver

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 8: bits per transfer, legal range 2..32.
REQ-002 SHALL have parameter CLK_DIV, default 1: clk cycles per spi_clk half-period, legal range 1..255.
REQ-003 SHALL have parameter CPOL, default 0: spi_clk idle level.
REQ-004 SHALL have parameter CPHA, default 0: 0 = sample on leading edge, 1 = sample on trailing edge.
REQ-005 SHALL have parameter LSB_FIRST, default 0: 0 = MSB shifted first, 1 = LSB shifted first.
REQ-006 SHALL have port clk, input, 1 bit: the single system clock; all logic runs on its rising edge.
REQ-007 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port execute, input, 1 bit: start request, sampled on each clk rising edge.
REQ-009 SHALL have port out_word, input, WORD_WIDTH bits: word to transmit, latched when execute is accepted.
REQ-010 SHALL have port cs_hold, input, 1 bit: latched with execute; 1 keeps cs_n low after the word completes.
REQ-011 SHALL have port miso, input, 1 bit: serial data from the peripheral.
REQ-012 SHALL have port spi_clk, output, 1 bit: serial clock.
REQ-013 SHALL have port mosi, output, 1 bit: serial data to the peripheral.
REQ-014 SHALL have port cs_n, output, 1 bit: active-low chip select.
REQ-015 SHALL have port in_word, output, WORD_WIDTH bits: last received word.
REQ-016 SHALL have port busy, output, 1 bit: high while a transfer is in progress.
REQ-017 SHALL have port finished, output, 1 bit: one-cycle pulse at transfer completion.

Function
REQ-018 SHALL implement FSM states IDLE, SHIFT, TRAIL, DONE.
REQ-019 SHALL accept execute only when busy=0: latch out_word and cs_hold, enter SHIFT next cycle with cs_n=0 and busy=1.
REQ-020 SHALL ignore execute while busy=1, with no effect on the latched word or cs_hold.
REQ-021 SHALL toggle spi_clk every CLK_DIV cycles in SHIFT, with the first toggle CLK_DIV cycles after SHIFT entry, for exactly 2*WORD_WIDTH edges.
REQ-022 SHALL drive the first mosi bit on SHIFT entry when CPHA=0, or on the first leading edge when CPHA=1; subsequent bits SHALL change on the non-sampling edge.
REQ-023 SHALL sample miso on the clk cycle of each sampling edge, WORD_WIDTH samples total, assembled per LSB_FIRST.
REQ-024 SHALL, after the last edge, hold spi_clk at CPOL for one half-period (TRAIL), then enter DONE for exactly one cycle.
REQ-025 SHALL, in DONE, pulse finished=1, set busy=0, and update in_word; in_word SHALL stay unchanged at all other times.
REQ-026 SHALL place finished exactly 1+(2*WORD_WIDTH+1)*CLK_DIV cycles after the execute acceptance edge.
REQ-027 SHALL, in DONE: raise cs_n to 1 when the latched cs_hold=0; keep cs_n=0 when cs_hold=1.
REQ-028 SHALL accept execute during the DONE cycle (back-to-back), entering SHIFT next cycle; when cs_hold=1, cs_n SHALL not glitch high.
REQ-029 SHALL, in IDLE, drive spi_clk=CPOL and mosi=1; cs_n SHALL follow REQ-027 until the next transfer.
REQ-030 SHALL drop a held cs_n (cs_hold=1) only by a transfer with cs_hold=0, or by reset.

Reset
REQ-031 SHALL, on reset=1 at a clk edge, force IDLE with spi_clk=CPOL, mosi=1, cs_n=1, busy=0, finished=0, in_word=0, and all counters cleared.
REQ-032 SHALL let reset mid-transfer abort with no finished pulse and leave in_word at 0.
REQ-033 SHALL give reset priority over a simultaneous execute, which is ignored.

Verification
REQ-034 SHALL cover: defaults, miso looped to mosi, out_word=0xA6 -> mosi 1,0,1,0,0,1,1,0 on rising edges, finished at cycle 18, in_word=0xA6, cs_n high after.
REQ-035 SHALL cover: CPOL=1/CPHA=1, out_word=0xC3 with loopback -> spi_clk idles 1, sampling on rising edges, in_word=0xC3.
REQ-036 SHALL cover: back-to-back 0xA6 (cs_hold=1) then 0xC3 (cs_hold=0) issued in the DONE cycle -> cs_n low continuously, two finished pulses 18 cycles apart, cs_n high after the second.
REQ-037 SHALL cover: execute pulsed with out_word=0xFF mid-transfer of 0xA6 -> ignored, in_word=0xA6.
REQ-038 SHALL cover: reset asserted at cycle 7 of a transfer -> next cycle cs_n=1, spi_clk=CPOL, busy=0, no finished pulse.
REQ-039 SHALL cover: WORD_WIDTH=16, CLK_DIV=4, LSB_FIRST=1, 0x1234 loopback -> first mosi bit 0, finished at cycle 133, in_word=0x1234.
